// File: rtl/pipe_adder_pkg.sv
// Shared parameters, helpers and stage-register layout for pipelined_carry_adder.
// Optional macro PIPE_ADDER_OVF_EN adds the signed-overflow sign-carry field.
package pipe_adder_pkg;

  localparam int unsigned PIPE_ADDER_WIDTH_DEF  = 16;
  localparam int unsigned PIPE_ADDER_STAGES_DEF = 4;
  // Stage-register fields are sized for the widest supported adder; unused bits stay zero.
  localparam int unsigned PIPE_ADDER_WIDTH_MAX  = 64;

  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                            valid;
    logic [PIPE_ADDER_WIDTH_MAX-1:0] sum_lo;
    logic                            carry;
`ifdef PIPE_ADDER_OVF_EN
    logic                            sign_c;
`endif
    logic [PIPE_ADDER_WIDTH_MAX-1:0] a_hi;
    logic [PIPE_ADDER_WIDTH_MAX-1:0] b_hi;
  } stage_reg_t;

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_adder.
// ovf is present only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_carry_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_ADDER_WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry adder slice used once per pipeline stage.
module adder_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < int'(SEG); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into STAGES ripple segments with a registered carry between stages.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_carry_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = PIPE_ADDER_WIDTH_DEF,
  parameter int unsigned STAGES = PIPE_ADDER_STAGES_DEF
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_carry_adder_if.slave bus
);

  if (STAGES < 1 || (WIDTH % STAGES) != 0 || WIDTH > PIPE_ADDER_WIDTH_MAX) begin : g_param_check
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES (STAGES >= 1)");
  end

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);

  stage_reg_t        stage_q_arr [STAGES];
  logic [STAGES-1:0] valid_vec;
  logic [STAGES:0]   ready;

  // A stage can load when empty or when its occupant moves on this same edge.
  always_comb begin
    ready         = '0;
    ready[STAGES] = bus.out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready[k] = !valid_vec[k] || ready[k+1];
    end
  end

  assign bus.in_ready = ready[0];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    stage_reg_t     up;
    stage_reg_t     stage_d;
    stage_reg_t     stage_q;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;

    if (k == 0) begin : g_src_in
      always_comb begin
        up                 = '0;
        up.valid           = bus.in_valid;
        up.carry           = bus.cin;
        up.a_hi[WIDTH-1:0] = bus.a;
        up.b_hi[WIDTH-1:0] = bus.b;
      end
    end else begin : g_src_stage
      assign up = stage_q_arr[k-1];
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a_i    (up.a_hi[k*SEG +: SEG]),
      .b_i    (up.b_hi[k*SEG +: SEG]),
      .cin_i  (up.carry),
      .sum_o  (seg_sum),
      .cout_o (seg_cout)
    );

    always_comb begin
      stage_d = stage_q;
      if (ready[k]) begin
        stage_d                      = up;
        stage_d.sum_lo[k*SEG +: SEG] = seg_sum;
        stage_d.carry                = seg_cout;
`ifdef PIPE_ADDER_OVF_EN
        // Carry into this segment's top bit; only the last stage's copy reaches ovf.
        stage_d.sign_c = up.a_hi[k*SEG+SEG-1] ^ up.b_hi[k*SEG+SEG-1] ^ seg_sum[SEG-1];
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign stage_q_arr[k] = stage_q;
    assign valid_vec[k]   = stage_q.valid;
  end

  assign bus.out_valid = stage_q_arr[STAGES-1].valid;
  assign bus.sum       = stage_q_arr[STAGES-1].sum_lo[WIDTH-1:0];
  assign bus.cout      = stage_q_arr[STAGES-1].carry;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = stage_q_arr[STAGES-1].sign_c ^ stage_q_arr[STAGES-1].carry;
`endif

  // Consumed operand bits and upper padding of the final stage are intentionally dropped.
  logic unused_last;
  assign unused_last = ^stage_q_arr[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4) with a queue-based model.
module tb_pipelined_carry_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;

  pipelined_carry_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_carry_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  exp_t exp_q[$];

  logic [15:0] bp_a [6] = '{16'h0001, 16'h00FF, 16'h8000, 16'hFFFF, 16'h1234, 16'hAAAA};
  logic [15:0] bp_b [6] = '{16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'hEDCB, 16'h5555};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain integer addition; overflow when like-signed operands give a differently-signed sum.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    e.cyc  = 0;
    return e;
  endfunction

  exp_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_cout;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_sum", 32'(bus.sum), 32'(prev_sum));
        check("stall_cout", 32'(bus.cout), 32'(prev_cout));
      end
      check("stale_result", 32'(bus.out_valid && exp_q.size() == 0), 32'd0);
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("model_sum", 32'(bus.sum), 32'(mon_e.sum));
        check("model_cout", 32'(bus.cout), 32'(mon_e.cout));
`ifdef PIPE_ADDER_OVF_EN
        check("model_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
        check("latency_min", 32'((cyc - mon_e.cyc) >= int'(STAGES)), 32'd1);
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e     = model(bus.a, bus.b, bus.cin);
        mon_e.cyc = cyc;
        exp_q.push_back(mon_e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.sum;
      prev_cout  = bus.cout;
    end
  end

  // Single operation into an empty pipe with out_ready held high.
  task automatic single_op(input string name, input logic [15:0] ai, input logic [15:0] bi,
                           input logic ci, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    bus.a         = ai;
    bus.b         = bi;
    bus.cin       = ci;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_sum"}, 32'(bus.sum), 32'(es));
    check({name, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef PIPE_ADDER_OVF_EN
    check({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo !== eo) $display("unreachable");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    int   idx, drop_at, start, ov_cnt, rdy_cnt;
    logic acc;

    pin = model(16'hFFFF, 16'h0001, 1'b0);
    check("model_pin_wrap", {15'd0, pin.cout, pin.sum}, 32'h0001_0000);
    pin = model(16'h7FFF, 16'h0001, 1'b0);
    check("model_pin_ovf", {15'd0, pin.ovf, pin.sum}, 32'h0001_8000);

    // Reset held with a valid request pending.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h4321;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_sum", 32'(bus.sum), 32'd0);
      check("reset_cout", 32'(bus.cout), 32'd0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    single_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    single_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_op("carry_cin", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

    // Backpressure: 6 operands against a stalled consumer, released at c==9.
    bus.out_ready = 1'b0;
    idx           = 0;
    drop_at       = -1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 6) begin
        bus.in_valid = 1'b1;
        bus.a        = bp_a[idx];
        bus.b        = bp_b[idx];
        bus.cin      = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (c == 9) bus.out_ready = 1'b1;
      @(negedge clk);
      if (c == 9) check("full_pipe_in_ready", 32'(bus.in_ready), 32'd1);
      if (!bus.in_ready && drop_at < 0) drop_at = idx;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("bp_drop_after", 32'(drop_at), 32'd4);
    check("bp_accepts", 32'(idx), 32'd6);
    drain("bp");

    // Full throughput with random operands.
    start   = n_out;
    ov_cnt  = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 104; i++) begin
      if (i < 100) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 4 && bus.out_valid) ov_cnt++;
      if (bus.in_ready) rdy_cnt++;
      @(posedge clk);
      #1;
    end
    check("tp_out_cycles", 32'(ov_cnt), 32'd100);
    check("tp_in_ready", 32'(rdy_cnt), 32'd104);
    drain("tp");
    check("tp_results", 32'(n_out - start), 32'd100);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111 * 16'(i + 1);
      bus.b        = 16'h0F0F;
      bus.cin      = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    single_op("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
